cvxif_copro_router: RTL and testbench
=====================================

Name: cvxif_copro_router

Overview:
- Successor to the single-coprocessor CV-X-IF hookup at the core top level.
- Lets one CVA6 core drive NrCopro coprocessors:
  - routes each issued instruction to the coprocessor whose major opcode matches;
  - tracks in-flight instruction ids;
  - forwards commit/kill to the coprocessor that owns the id;
  - round-robin arbitrates coprocessor results into one registered result channel back to the core.
- Sits between the core's CV-X-IF port and the coprocessor instances.

Parameters:
- NrCopro, 2, number of attached coprocessors (1..8).
- IdWidth, 3, instruction id width; id table depth is 2**IdWidth.
- InstrWidth, 32, instruction word width.
- ResultWidth, 64, result data width (XLEN).
- RegAddrWidth, 5, destination register address width.
- CoproOpcode, {7'h0B,7'h2B}, per-coprocessor 7-bit major opcode, array [NrCopro].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- issue_valid_i  in  1  core issue request
- issue_ready_o  out  1  router can take issue this cycle
- issue_instr_i  in  InstrWidth  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_accept_o  out  1  instruction claimed by a coprocessor (valid with issue handshake)
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  IdWidth  id being committed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result to core
- result_ready_i  in  1  core accepts result
- result_id_o  out  IdWidth  result id
- result_data_o  out  ResultWidth  result data
- result_rd_o  out  RegAddrWidth  destination register
- result_we_o  out  1  register write enable
- cp_issue_valid_o  out  NrCopro  per-coprocessor issue valid
- cp_issue_ready_i  in  NrCopro  per-coprocessor issue ready
- cp_issue_instr_o  out  InstrWidth  broadcast instruction
- cp_issue_id_o  out  IdWidth  broadcast id
- cp_commit_valid_o  out  NrCopro  per-coprocessor commit strobe
- cp_commit_id_o  out  IdWidth  broadcast commit id
- cp_commit_kill_o  out  1  broadcast kill flag
- cp_result_valid_i  in  NrCopro  per-coprocessor result valid
- cp_result_ready_o  out  NrCopro  per-coprocessor result ready (grant)
- cp_result_i  in  NrCopro x (IdWidth+ResultWidth+RegAddrWidth+1)  packed {id,data,rd,we}
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high at a clock edge, including mid-transaction):
  - id table cleared: all in-flight bits 0;
  - result register empty: result_valid_o=0, result_id/data/rd/we=0;
  - round-robin pointer=0, err_o=0.
- Issue routing is combinational:
  - match[i] = (issue_instr_i[6:0]==CoproOpcode[i]); lowest matching index wins.
  - busy = inflight[issue_id_i].
  - issue_ready_o = !busy && (no match || cp_issue_ready_i[sel]).
  - cp_issue_valid_o[sel] = issue_valid_i && !busy on a match; all other bits 0.
  - issue_accept_o = match (meaningful when issue_valid_i && issue_ready_o).
  - No match: handshake completes in the same cycle with issue_accept_o=0; no table update.
- Issue handshake with a match sets inflight[id]=1 and owner[id]=sel at the edge.
- Commit:
  - if commit_valid_i and inflight[commit_id_i]: cp_commit_valid_o[owner]=1, same cycle.
  - if kill: inflight cleared at the edge.
  - if commit_valid_i for an id that is not in flight: no strobe, err_o set.
- Result arbitration:
  - round-robin over cp_result_valid_i, starting at the pointer.
  - a grant occurs when the result register is empty, or being drained this cycle (result_ready_i && result_valid_o).
  - on a grant: cp_result_ready_o[g]=1, the packed result is registered, the pointer moves to g+1 mod NrCopro.
  - latency: 1 cycle from grant to result_valid_o.
  - back-to-back results sustain 1 per cycle.
- On a result grant:
  - id in flight and owner==g: inflight cleared.
  - otherwise (killed or unknown id): result dropped (not registered), err_o set, grant still given.
- Output hold: result_valid_o and all result_* fields stay stable until result_ready_i.
- Same-cycle events:
  - issue and result-clear of the same id: the clear happens first, so the new issue is accepted and the bit ends at 1.
  - kill and result of the same id: the kill wins and the result is dropped with err_o set.
- err_o is cleared only by reset.

Decomposition:
- Package cvxif_router_pkg holds:
  - the result struct type {id,data,rd,we} parametrised via localparam widths;
  - OpcodeWidth=7.
- Sub-module rr_arb_nc: NrCopro-input round-robin arbiter with pointer register, reused by the result path.

Test Plan:
- Opcode 7'h2B, id 3, both coprocessors ready -> cp_issue_valid_o=2'b10, issue_accept_o=1, inflight[3]=1.
- Opcode 7'h33 -> issue_ready_o=1, issue_accept_o=0, cp_issue_valid_o=0, table unchanged.
- Reissue of id 3 while it is in flight -> issue_ready_o=0 until copro 1 returns a result with id 3. On the handshake cycle, a new issue of id 3 is accepted.
- Both coprocessors hold results continuously, result_ready_i=1 -> grants alternate 0,1,0,1; one result_valid_o per cycle; data matches the granted source one cycle later.
- Kill id 5, then copro 0 returns id 5 -> result dropped, result_valid_o stays 0, err_o=1.
- Reset asserted while result_valid_o=1 with result_ready_i=0 -> next cycle result_valid_o=0, err_o=0, every id issuable.

Source files
------------

// File: rtl/cvxif_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_router_pkg
// Purpose  : Shared types and constants for the CV-X-IF coprocessor router.
//            Holds the major-opcode width and the default-width packed
//            result record {id, data, rd, we} returned by a coprocessor.
// Revision : 1.0 - initial release
// ============================================================================
package cvxif_router_pkg;

    // Width of the RISC-V major opcode field (instr[6:0]).
    localparam int OpcodeWidth     = 7;

    // Default field widths of a coprocessor result record.
    localparam int ResIdWidth      = 3;
    localparam int ResDataWidth    = 64;
    localparam int ResRegAddrWidth = 5;

    // Layout of one coprocessor result, most significant field first.
    typedef struct packed {
        logic [ResIdWidth-1:0]      id;
        logic [ResDataWidth-1:0]    data;
        logic [ResRegAddrWidth-1:0] rd;
        logic                       we;
    } result_t;

endpackage : cvxif_router_pkg
`default_nettype wire

// File: rtl/rr_arb_nc.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_nc
// Purpose  : N-input round-robin arbiter with an internal priority pointer.
//            Search starts at the pointer; after a grant the pointer moves to
//            the slot just past the winner.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_req [N]    - request vector
//            i_en         - grant permitted this cycle
//            o_gnt [N]    - one-hot grant (zero when nothing granted)
//            o_idx        - index of the granted requester
//            o_any        - a grant is issued this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_nc #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] r_ptr;

    always_comb begin
        int   w_c;
        logic w_found;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int k = 0; k < N; k++) begin
            // Walk the requesters circularly starting from the pointer.
            w_c = int'(r_ptr) + k;
            if (w_c >= N) begin
                w_c = w_c - N;
            end
            if (i_en && !w_found && i_req[IDX_W'(w_c)]) begin
                w_found = 1'b1;
                o_idx   = IDX_W'(w_c);
            end
        end
        if (w_found) begin
            o_gnt[o_idx] = 1'b1;
        end
        o_any = w_found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (o_idx == IDX_W'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule : rr_arb_nc
`default_nettype wire

// File: rtl/cvxif_copro_router.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_copro_router
// Purpose  : Connects one CVA6 CV-X-IF port to NrCopro coprocessors. Issues
//            are steered by major opcode, in-flight ids are tracked with
//            their owner, commit/kill is forwarded to the owner, and results
//            are round-robin merged into one registered result channel.
// Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//            issue_*               - core issue channel
//            commit_*              - core commit/kill strobe
//            result_*              - registered result channel to the core
//            cp_issue_*            - per-coprocessor issue (instr/id broadcast)
//            cp_commit_*           - per-coprocessor commit strobe
//            cp_result_*           - per-coprocessor results, packed
//                                    {id,data,rd,we}, ready acts as grant
//            err_o                 - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module cvxif_copro_router
    import cvxif_router_pkg::*;
#(
    parameter int NrCopro      = 2,
    parameter int IdWidth      = 3,
    parameter int InstrWidth   = 32,
    parameter int ResultWidth  = 64,
    parameter int RegAddrWidth = 5,
    parameter logic [OpcodeWidth-1:0] CoproOpcode [NrCopro] = '{7'h0B, 7'h2B}
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [InstrWidth-1:0]     issue_instr_i,
    input  logic [IdWidth-1:0]        issue_id_i,
    output logic                      issue_accept_o,
    input  logic                      commit_valid_i,
    input  logic [IdWidth-1:0]        commit_id_i,
    input  logic                      commit_kill_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [IdWidth-1:0]        result_id_o,
    output logic [ResultWidth-1:0]    result_data_o,
    output logic [RegAddrWidth-1:0]   result_rd_o,
    output logic                      result_we_o,
    output logic [NrCopro-1:0]        cp_issue_valid_o,
    input  logic [NrCopro-1:0]        cp_issue_ready_i,
    output logic [InstrWidth-1:0]     cp_issue_instr_o,
    output logic [IdWidth-1:0]        cp_issue_id_o,
    output logic [NrCopro-1:0]        cp_commit_valid_o,
    output logic [IdWidth-1:0]        cp_commit_id_o,
    output logic                      cp_commit_kill_o,
    input  logic [NrCopro-1:0]        cp_result_valid_i,
    output logic [NrCopro-1:0]        cp_result_ready_o,
    input  logic [NrCopro*(IdWidth+ResultWidth+RegAddrWidth+1)-1:0] cp_result_i,
    output logic                      err_o
);

    localparam int SelW  = (NrCopro > 1) ? $clog2(NrCopro) : 1;
    localparam int ResW  = IdWidth + ResultWidth + RegAddrWidth + 1;
    localparam int Depth = 1 << IdWidth;

    // Id table: in-flight flag and owning coprocessor per id.
    logic [Depth-1:0]        r_inflight;
    logic [SelW-1:0]         r_owner [Depth];

    // Result register towards the core.
    logic                    r_res_valid;
    logic [IdWidth-1:0]      r_res_id;
    logic [ResultWidth-1:0]  r_res_data;
    logic [RegAddrWidth-1:0] r_res_rd;
    logic                    r_res_we;
    logic                    r_err;

    logic                    w_match;
    logic [SelW-1:0]         w_sel;
    logic                    w_busy;
    logic                    w_issue_fire;
    logic                    w_commit_hit;
    logic                    w_kill_hit;
    logic                    w_grant_en;
    logic                    w_gnt;
    logic [SelW-1:0]         w_gnt_idx;
    logic [ResW-1:0]         w_cp_res [NrCopro];
    logic [ResW-1:0]         w_gnt_res;
    logic [IdWidth-1:0]      w_gnt_id;
    logic                    w_res_ok;
    logic                    w_res_clear;
    logic [InstrWidth-1:0]   w_unused_instr;

    assign w_unused_instr = issue_instr_i;

    // ------------------------------------------------------------------
    // Issue routing: lowest-index opcode match wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_match = 1'b0;
        w_sel   = '0;
        for (int i = NrCopro - 1; i >= 0; i--) begin
            if (issue_instr_i[OpcodeWidth-1:0] == CoproOpcode[i]) begin
                w_match = 1'b1;
                w_sel   = SelW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result arbitration
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NrCopro; gi++) begin : g_unpack
        assign w_cp_res[gi] = cp_result_i[gi*ResW +: ResW];
    end

    // A new result may be taken when the register is empty or draining.
    assign w_grant_en = !r_res_valid || result_ready_i;

    rr_arb_nc #(
        .N     (NrCopro),
        .IDX_W (SelW)
    ) u_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .i_req (cp_result_valid_i),
        .i_en  (w_grant_en),
        .o_gnt (cp_result_ready_o),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt)
    );

    assign w_gnt_res  = w_cp_res[w_gnt_idx];
    assign w_gnt_id   = w_gnt_res[ResW-1 -: IdWidth];

    assign w_commit_hit = commit_valid_i && r_inflight[commit_id_i];
    assign w_kill_hit   = w_commit_hit && commit_kill_i;

    // A same-cycle kill of the granted id takes priority over its result.
    assign w_res_ok    = r_inflight[w_gnt_id] && (r_owner[w_gnt_id] == w_gnt_idx)
                         && !(w_kill_hit && (commit_id_i == w_gnt_id));
    assign w_res_clear = w_gnt && w_res_ok;

    // An id being retired by a result this cycle is already free for issue.
    assign w_busy = r_inflight[issue_id_i] && !(w_res_clear && (w_gnt_id == issue_id_i));

    assign issue_ready_o  = !w_busy && (!w_match || cp_issue_ready_i[w_sel]);
    assign issue_accept_o = w_match;
    assign w_issue_fire   = issue_valid_i && issue_ready_o && w_match;

    always_comb begin
        cp_issue_valid_o = '0;
        if (issue_valid_i && !w_busy && w_match) begin
            cp_issue_valid_o[w_sel] = 1'b1;
        end
    end

    assign cp_issue_instr_o = issue_instr_i;
    assign cp_issue_id_o    = issue_id_i;

    always_comb begin
        cp_commit_valid_o = '0;
        if (w_commit_hit) begin
            cp_commit_valid_o[r_owner[commit_id_i]] = 1'b1;
        end
    end

    assign cp_commit_id_o   = commit_id_i;
    assign cp_commit_kill_o = commit_kill_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight  <= '0;
            for (int j = 0; j < Depth; j++) begin
                r_owner[j] <= '0;
            end
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_res_we    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Clears first, then the issue set, so an issue reusing an id
            // retired in the same cycle leaves the id in flight.
            if (w_res_clear) begin
                r_inflight[w_gnt_id] <= 1'b0;
            end
            if (w_kill_hit) begin
                r_inflight[commit_id_i] <= 1'b0;
            end
            if (w_issue_fire) begin
                r_inflight[issue_id_i] <= 1'b1;
                r_owner[issue_id_i]    <= w_sel;
            end

            if ((w_gnt && !w_res_ok) || (commit_valid_i && !r_inflight[commit_id_i])) begin
                r_err <= 1'b1;
            end

            if (w_res_clear) begin
                r_res_valid <= 1'b1;
                r_res_id    <= w_gnt_id;
                r_res_data  <= w_gnt_res[RegAddrWidth+1 +: ResultWidth];
                r_res_rd    <= w_gnt_res[1 +: RegAddrWidth];
                r_res_we    <= w_gnt_res[0];
            end else if (result_ready_i && r_res_valid) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign result_valid_o = r_res_valid;
    assign result_id_o    = r_res_id;
    assign result_data_o  = r_res_data;
    assign result_rd_o    = r_res_rd;
    assign result_we_o    = r_res_we;
    assign err_o          = r_err;

endmodule : cvxif_copro_router
`default_nettype wire

// File: tb/tb_cvxif_copro_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_copro_router
// Purpose  : Self-checking bench for cvxif_copro_router (2 coprocessors,
//            opcodes 0x0B / 0x2B). Directed steps followed by random traffic,
//            compared against a behavioural model of the id table, owner
//            map, round-robin pointer and result register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvxif_copro_router;

    localparam int N  = 2;
    localparam int IW = 3;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int PW = IW + DW + RW + 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [31:0]       issue_instr_i;
    logic [IW-1:0]     issue_id_i;
    logic              issue_accept_o;
    logic              commit_valid_i;
    logic [IW-1:0]     commit_id_i;
    logic              commit_kill_i;
    logic              result_valid_o;
    logic              result_ready_i;
    logic [IW-1:0]     result_id_o;
    logic [DW-1:0]     result_data_o;
    logic [RW-1:0]     result_rd_o;
    logic              result_we_o;
    logic [N-1:0]      cp_issue_valid_o;
    logic [N-1:0]      cp_issue_ready_i;
    logic [31:0]       cp_issue_instr_o;
    logic [IW-1:0]     cp_issue_id_o;
    logic [N-1:0]      cp_commit_valid_o;
    logic [IW-1:0]     cp_commit_id_o;
    logic              cp_commit_kill_o;
    logic [N-1:0]      cp_result_valid_i;
    logic [N-1:0]      cp_result_ready_o;
    logic [N*PW-1:0]   cp_result_i;
    logic              err_o;

    // Per-source result fields driven by the stimulus.
    logic [IW-1:0]     src_id   [N];
    logic [DW-1:0]     src_data [N];
    logic [RW-1:0]     src_rd   [N];
    logic              src_we   [N];

    assign cp_result_i = {src_id[1], src_data[1], src_rd[1], src_we[1],
                          src_id[0], src_data[0], src_rd[0], src_we[0]};

    always #5 clk_i = ~clk_i;

    cvxif_copro_router dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_accept_o    (issue_accept_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o),
        .cp_issue_valid_o  (cp_issue_valid_o),
        .cp_issue_ready_i  (cp_issue_ready_i),
        .cp_issue_instr_o  (cp_issue_instr_o),
        .cp_issue_id_o     (cp_issue_id_o),
        .cp_commit_valid_o (cp_commit_valid_o),
        .cp_commit_id_o    (cp_commit_id_o),
        .cp_commit_kill_o  (cp_commit_kill_o),
        .cp_result_valid_i (cp_result_valid_i),
        .cp_result_ready_o (cp_result_ready_o),
        .cp_result_i       (cp_result_i),
        .err_o             (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    bit            m_inflight [8];
    int            m_owner    [8];
    int            m_ptr;
    bit            m_rv;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [RW-1:0] m_rrd;
    logic          m_rwe;
    bit            m_err;
    bit            m_just_reset;

    // Per-cycle expectations
    bit            e_match;
    int            e_sel;
    bit            e_gnt_any;
    int            e_g;
    bit            e_ok;
    bit            e_busy;
    bit            e_ready;
    logic [N-1:0]  e_cpv;
    logic [N-1:0]  e_commit;
    logic [N-1:0]  e_cprr;

    logic [6:0]    opc [N] = '{7'h0B, 7'h2B};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_inflight[i] = 1'b0;
            m_owner[i]    = 0;
        end
        m_ptr = 0; m_rv = 1'b0; m_rid = '0; m_rdata = '0; m_rrd = '0; m_rwe = 1'b0;
        m_err = 1'b0; m_just_reset = 1'b1;
    endtask

    task automatic model_comb();
        logic [6:0] op;
        int         rid;
        op = issue_instr_i[6:0];
        e_match = 1'b0; e_sel = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (op == opc[i]) begin e_match = 1'b1; e_sel = i; end
        end
        e_gnt_any = 1'b0; e_g = 0; e_ok = 1'b0; rid = 0;
        if (!m_rv || result_ready_i) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!e_gnt_any && cp_result_valid_i[c]) begin e_gnt_any = 1'b1; e_g = c; end
            end
        end
        if (e_gnt_any) begin
            rid  = int'(src_id[e_g]);
            e_ok = m_inflight[rid] && (m_owner[rid] == e_g)
                   && !(commit_valid_i && commit_kill_i && int'(commit_id_i) == rid);
        end
        e_busy  = m_inflight[issue_id_i] && !(e_gnt_any && e_ok && rid == int'(issue_id_i));
        e_ready = !e_busy && (!e_match || cp_issue_ready_i[e_sel]);
        e_cpv   = '0;
        if (issue_valid_i && !e_busy && e_match) e_cpv[e_sel] = 1'b1;
        e_commit = '0;
        if (commit_valid_i && m_inflight[commit_id_i]) e_commit[m_owner[commit_id_i]] = 1'b1;
        e_cprr = '0;
        if (e_gnt_any) e_cprr[e_g] = 1'b1;
    endtask

    task automatic model_update();
        bit cv_hit;
        if (rst_i) begin
            model_reset();
            return;
        end
        m_just_reset = 1'b0;
        cv_hit = commit_valid_i && m_inflight[commit_id_i];
        if (e_gnt_any) begin
            m_ptr = (e_g + 1) % N;
            if (e_ok) m_inflight[src_id[e_g]] = 1'b0;
            else      m_err = 1'b1;
        end
        if (commit_valid_i) begin
            if (cv_hit) begin
                if (commit_kill_i) m_inflight[commit_id_i] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (issue_valid_i && e_ready && e_match) begin
            m_inflight[issue_id_i] = 1'b1;
            m_owner[issue_id_i]    = e_sel;
        end
        if (e_gnt_any && e_ok) begin
            m_rv = 1'b1; m_rid = src_id[e_g]; m_rdata = src_data[e_g];
            m_rrd = src_rd[e_g]; m_rwe = src_we[e_g];
        end else if (result_ready_i && m_rv) begin
            m_rv = 1'b0;
        end
    endtask

    // One clock: check combinational outputs, clock, check registered outputs.
    task automatic cycle();
        #1;
        model_comb();
        chk("issue_ready",  issue_ready_o,     e_ready);
        chk("issue_accept", issue_accept_o,    e_match);
        chk("cp_issue_vld", cp_issue_valid_o,  e_cpv);
        chk("cp_issue_id",  cp_issue_id_o,     issue_id_i);
        chk("cp_commit",    cp_commit_valid_o, e_commit);
        chk("cp_commit_k",  cp_commit_kill_o,  commit_kill_i);
        chk("cp_res_ready", cp_result_ready_o, e_cprr);
        @(posedge clk_i);
        model_update();
        #1;
        chk("result_valid", result_valid_o, m_rv);
        chk("err",          err_o,          m_err);
        if (m_rv || m_just_reset) begin
            chk("result_id",   result_id_o,   m_rid);
            chk("result_data", result_data_o, m_rdata);
            chk("result_rd",   result_rd_o,   m_rrd);
            chk("result_we",   result_we_o,   m_rwe);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i = 1'b0; issue_instr_i = 32'h0; issue_id_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        result_ready_i = 1'b1; cp_issue_ready_i = '1; cp_result_valid_i = '0;
        for (int i = 0; i < N; i++) begin
            src_id[i] = '0; src_data[i] = '0; src_rd[i] = '0; src_we[i] = 1'b0;
        end
    endtask

    task automatic set_src(input int s, input int id);
        logic [31:0] a, b;
        a = $urandom(); b = $urandom();
        src_id[s]   = IW'(id);
        src_data[s] = {a, b};
        src_rd[s]   = RW'($urandom_range(0, 31));
        src_we[s]   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_issue(input logic [6:0] op, input int id);
        logic [31:0] r;
        r = $urandom();
        issue_valid_i = 1'b1;
        issue_instr_i = {r[31:7], op};
        issue_id_i    = IW'(id);
    endtask

    int alt_ids0 [2] = '{0, 1};
    int alt_ids1 [2] = '{3, 4};

    initial begin
        int a0, a1;
        model_reset();
        idle_inputs();

        // Reset
        rst_i = 1'b1;
        cycle(); cycle();
        rst_i = 1'b0;

        // Opcode 0x2B, id 3 -> copro 1
        do_issue(7'h2B, 3);
        cycle();
        // Unclaimed opcode: completes with accept=0
        do_issue(7'h33, 4);
        cycle();
        // Reissue of in-flight id 3 is stalled
        do_issue(7'h2B, 3);
        cycle(); cycle();
        // Copro 1 returns id 3 while id 3 is reissued in the same cycle
        cp_result_valid_i = 2'b10; set_src(1, 3);
        cycle();
        cp_result_valid_i = '0; issue_valid_i = 1'b0;
        cycle();

        // Fill ids for alternating results
        do_issue(7'h0B, 0); cycle();
        do_issue(7'h0B, 1); cycle();
        do_issue(7'h2B, 4); cycle();
        issue_valid_i = 1'b0;

        // Both sources hold results continuously
        a0 = 0; a1 = 0;
        cp_result_valid_i = 2'b11;
        set_src(0, alt_ids0[0]); set_src(1, alt_ids1[0]);
        for (int t = 0; t < 4; t++) begin
            cycle();
            if (e_gnt_any && e_g == 0) begin a0++; if (a0 < 2) set_src(0, alt_ids0[a0]); else cp_result_valid_i[0] = 1'b0; end
            if (e_gnt_any && e_g == 1) begin a1++; if (a1 < 2) set_src(1, alt_ids1[a1]); else cp_result_valid_i[1] = 1'b0; end
        end
        cp_result_valid_i = '0;
        cycle();

        // Kill id 5, then a stale result for id 5 arrives
        do_issue(7'h0B, 5); cycle();
        issue_valid_i = 1'b0;
        commit_valid_i = 1'b1; commit_id_i = 3'd5; commit_kill_i = 1'b1;
        cycle();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        cp_result_valid_i = 2'b01; set_src(0, 5);
        cycle();
        cp_result_valid_i = '0;
        cycle();

        // Reset while a result is held un-acknowledged
        do_issue(7'h0B, 6); cycle();
        issue_valid_i = 1'b0;
        result_ready_i = 1'b0;
        cp_result_valid_i = 2'b01; set_src(0, 6);
        cycle();
        cp_result_valid_i = '0;
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        result_ready_i = 1'b1;
        for (int id = 0; id < 8; id++) begin
            issue_id_i = IW'(id); issue_instr_i = 32'h0000_002B;
            cycle();
        end

        // Random traffic
        for (int t = 0; t < 800; t++) begin
            int sel;
            rst_i = (t == 400);
            issue_valid_i = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            do_issue(sel == 0 ? 7'h0B : (sel == 1 ? 7'h2B : 7'h33), $urandom_range(0, 7));
            issue_valid_i = 1'($urandom_range(0, 1));
            cp_issue_ready_i = 2'($urandom_range(0, 3));
            commit_valid_i = ($urandom_range(0, 3) == 0);
            commit_id_i    = IW'($urandom_range(0, 7));
            commit_kill_i  = 1'($urandom_range(0, 1));
            result_ready_i = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < N; s++) begin
                int id;
                id = $urandom_range(0, 7);
                // Prefer an id this source really owns.
                for (int tries = 0; tries < 8; tries++) begin
                    int c;
                    c = $urandom_range(0, 7);
                    if (m_inflight[c] && m_owner[c] == s) id = c;
                end
                cp_result_valid_i[s] = ($urandom_range(0, 1) == 0);
                set_src(s, id);
            end
            cycle();
        end
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cvxif_copro_router
`default_nettype wire
